// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker: locks onto the 4-bit spin sequence next = {d[1]^d[0], d[3:1]}.
// After lock it predicts each sample, and it flags and counts mismatches.
// It drops lock after UNLOCK_COUNT consecutive misses.
// Latency: each sample taken at edge N is reflected on all outputs right after edge N.
// Backpressure: none; the block samples whenever in_valid is high and never stalls the source.
// Ports:
//   clock, reset (sync, active-high)
//   in_valid/in_data : qualified spin register samples
//   clear_errs       : clears err_count (and period_count when present)
//   locked, error, zero_err, err_count, pred : registered status
// Optional: define LFSR_CHK_PERIOD_EN to add period_count/period_mark (sequence wrap marker).
module lfsr_seq_checker #(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 2,
  parameter int ERR_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  input  logic             clear_errs,
  output logic             locked,
  output logic             error,
  output logic             zero_err,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       pred
`ifdef LFSR_CHK_PERIOD_EN
  ,
  output logic [15:0]      period_count,
  output logic             period_mark
`endif
);

  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [3:0] LC_MAX = 4'(LOCK_COUNT);
  localparam logic [2:0] UC_MAX = 3'(UNLOCK_COUNT);

  function automatic logic [3:0] f_nxt(input logic [3:0] x);
    return {x[1] ^ x[0], x[3:1]};
  endfunction

  state_t           r_state, w_state;
  logic [3:0]       r_match_cnt, w_match_cnt;
  logic [2:0]       r_miss_cnt, w_miss_cnt;
  logic             r_locked, w_locked;
  logic             r_error, w_error;
  logic             r_zero_err, w_zero_err;
  logic [ERR_W-1:0] r_err_count, w_err_count;
  logic [3:0]       r_pred, w_pred;
  logic [3:0]       w_match_inc;
  logic [2:0]       w_miss_inc;
`ifdef LFSR_CHK_PERIOD_EN
  logic [15:0]      r_period_count, w_period_count;
  logic             r_period_mark, w_period_mark;
`endif

  assign w_match_inc = r_match_cnt + 4'd1;
  assign w_miss_inc  = r_miss_cnt + 3'd1;

  always_comb begin
    w_state     = r_state;
    w_match_cnt = r_match_cnt;
    w_miss_cnt  = r_miss_cnt;
    w_locked    = r_locked;
    w_error     = 1'b0;
    w_zero_err  = 1'b0;
    w_err_count = r_err_count;
    w_pred      = r_pred;
`ifdef LFSR_CHK_PERIOD_EN
    w_period_count = r_period_count;
    w_period_mark  = 1'b0;
`endif
    if (in_valid) begin
      if (in_data == 4'b0000) begin
        // All-zero is the LFSR lockup value: it can never be a legal sample,
        // so it beats any prediction match and forces a fresh hunt.
        w_zero_err  = 1'b1;
        w_state     = HUNT;
        w_locked    = 1'b0;
        w_match_cnt = 4'd0;
        w_miss_cnt  = 3'd0;
      end else begin
        case (r_state)
          HUNT: begin
            w_pred      = f_nxt(in_data);
            w_match_cnt = 4'd1;
            w_state     = VERIFY;
          end
          VERIFY: begin
            w_pred = f_nxt(in_data);
            if (in_data == r_pred) begin
              w_match_cnt = w_match_inc;
              if (w_match_inc == LC_MAX) begin
                w_state    = LOCKED;
                w_locked   = 1'b1;
                w_miss_cnt = 3'd0;
              end
            end else begin
              w_match_cnt = 4'd1;
            end
          end
          LOCKED: begin
            // Flywheel: the prediction advances from pred, not from the
            // observed value, so a single corrupted sample does not derail it.
            w_pred = f_nxt(r_pred);
            if (in_data == r_pred) begin
              w_miss_cnt = 3'd0;
`ifdef LFSR_CHK_PERIOD_EN
              if (in_data == 4'b0100) begin
                w_period_mark = 1'b1;
                if (r_period_count != 16'hFFFF) w_period_count = r_period_count + 16'd1;
              end
`endif
            end else begin
              w_error    = 1'b1;
              w_miss_cnt = w_miss_inc;
              if (r_err_count != {ERR_W{1'b1}}) w_err_count = r_err_count + ERR_W'(1);
              if (w_miss_inc == UC_MAX) begin
                w_state     = HUNT;
                w_locked    = 1'b0;
                w_pred      = 4'd0;
                w_match_cnt = 4'd0;
                w_miss_cnt  = 3'd0;
              end
            end
          end
          default: w_state = HUNT;
        endcase
      end
    end
    // Clear takes priority over a same-cycle increment.
    if (clear_errs) begin
      w_err_count = '0;
`ifdef LFSR_CHK_PERIOD_EN
      w_period_count = 16'd0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= HUNT;
      r_match_cnt <= 4'd0;
      r_miss_cnt  <= 3'd0;
      r_locked    <= 1'b0;
      r_error     <= 1'b0;
      r_zero_err  <= 1'b0;
      r_err_count <= '0;
      r_pred      <= 4'd0;
`ifdef LFSR_CHK_PERIOD_EN
      r_period_count <= 16'd0;
      r_period_mark  <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_match_cnt <= w_match_cnt;
      r_miss_cnt  <= w_miss_cnt;
      r_locked    <= w_locked;
      r_error     <= w_error;
      r_zero_err  <= w_zero_err;
      r_err_count <= w_err_count;
      r_pred      <= w_pred;
`ifdef LFSR_CHK_PERIOD_EN
      r_period_count <= w_period_count;
      r_period_mark  <= w_period_mark;
`endif
    end
  end

  assign locked    = r_locked;
  assign error     = r_error;
  assign zero_err  = r_zero_err;
  assign err_count = r_err_count;
  assign pred      = r_pred;
`ifdef LFSR_CHK_PERIOD_EN
  assign period_count = r_period_count;
  assign period_mark  = r_period_mark;
`endif

endmodule
